// File: rtl/btb_branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// It also registers the EX redirect, counts mispredicts and runs a table-flush sweep.
module btb_branch_predictor #(
  parameter int unsigned DBITS     = 32,
  parameter int unsigned INSTSIZE  = 4,
  parameter int unsigned INDEXBITS = 4,
  parameter int unsigned TAGBITS   = 10,
  parameter int unsigned CTRBITS   = 2,
  parameter int unsigned CNTBITS   = 16
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic [DBITS-1:0]   pc_FE,
  output logic [DBITS-1:0]   pcpred_FE,
  output logic               predtaken_FE,
  input  logic               upd_valid,
  input  logic [DBITS-1:0]   upd_pc,
  input  logic [DBITS-1:0]   upd_predpc,
  input  logic               upd_is_br,
  input  logic               upd_is_jmp,
  input  logic               upd_taken,
  input  logic [DBITS-1:0]   upd_target,
  input  logic               flush_req,
  output logic               busy,
  output logic               mispred_EX,
  output logic [DBITS-1:0]   pcgood_EX,
  output logic [CNTBITS-1:0] mispred_cnt
);

  localparam int unsigned ENTRIES = 1 << INDEXBITS;
  localparam logic [CTRBITS-1:0] CtrMax       = '1;
  localparam logic [CTRBITS-1:0] CtrWeakTaken = CTRBITS'(1 << (CTRBITS - 1));
  localparam logic [CTRBITS-1:0] CtrWeakNot   = CTRBITS'((1 << (CTRBITS - 1)) - 1);
  localparam logic [DBITS-1:0]   Inc          = DBITS'(INSTSIZE);
  localparam logic [INDEXBITS-1:0] LastIdx    = INDEXBITS'(ENTRIES - 1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e               state_q, state_d;
  logic [INDEXBITS-1:0] ptr_q, ptr_d;
  logic                 flush_start;

  logic                 valid_q  [ENTRIES];
  logic [TAGBITS-1:0]   tag_q    [ENTRIES];
  logic [DBITS-1:0]     target_q [ENTRIES];
  logic                 jmp_q    [ENTRIES];
  logic [CTRBITS-1:0]   ctr_q    [ENTRIES];

  // Fetch-side lookup
  logic [INDEXBITS-1:0] fe_idx;
  logic [TAGBITS-1:0]   fe_tag;
  logic                 fe_hit;

  assign fe_idx = pc_FE[INDEXBITS+1:2];
  assign fe_tag = pc_FE[TAGBITS+INDEXBITS+1:INDEXBITS+2];
  assign busy   = (state_q == StFlush);
  assign fe_hit = valid_q[fe_idx] && (tag_q[fe_idx] == fe_tag) && !busy;

  assign predtaken_FE = fe_hit && (jmp_q[fe_idx] || ctr_q[fe_idx][CTRBITS-1]);
  assign pcpred_FE    = predtaken_FE ? target_q[fe_idx] : pc_FE + Inc;

  // EX-side update of the single indexed entry
  logic [INDEXBITS-1:0] up_idx;
  logic [TAGBITS-1:0]   up_tag;
  logic                 up_hit, up_ctl, upd_en;
  logic                 wr_en;
  logic                 n_valid, n_jmp;
  logic [TAGBITS-1:0]   n_tag;
  logic [DBITS-1:0]     n_tgt;
  logic [CTRBITS-1:0]   n_ctr;

  assign up_idx = upd_pc[INDEXBITS+1:2];
  assign up_tag = upd_pc[TAGBITS+INDEXBITS+1:INDEXBITS+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctl = upd_is_br || upd_is_jmp;
  assign upd_en = upd_valid && !busy && !flush_req;

  always_comb begin
    wr_en   = 1'b0;
    n_valid = valid_q[up_idx];
    n_tag   = tag_q[up_idx];
    n_tgt   = target_q[up_idx];
    n_jmp   = jmp_q[up_idx];
    n_ctr   = ctr_q[up_idx];
    if (upd_en) begin
      if (up_ctl) begin
        if (up_hit) begin
          wr_en = 1'b1;
          if (upd_is_jmp) begin
            n_ctr = CtrMax;
            n_jmp = 1'b1;
          end else if (upd_taken) begin
            if (n_ctr != CtrMax) n_ctr = n_ctr + CTRBITS'(1);
          end else begin
            if (n_ctr != '0) n_ctr = n_ctr - CTRBITS'(1);
          end
          if (upd_taken) n_tgt = upd_target;
        end else if (upd_taken) begin
          wr_en   = 1'b1;
          n_valid = 1'b1;
          n_tag   = up_tag;
          n_tgt   = upd_target;
          n_jmp   = upd_is_jmp;
          n_ctr   = CtrWeakTaken;
        end
      end else if (up_hit) begin
        // A non-control instruction hitting an entry means a stale alias; drop it.
        wr_en   = 1'b1;
        n_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        jmp_q[i]    <= 1'b0;
        ctr_q[i]    <= CtrWeakNot;
      end
    end else if (busy) begin
      valid_q[ptr_q] <= 1'b0;
    end else if (wr_en) begin
      valid_q[up_idx]  <= n_valid;
      tag_q[up_idx]    <= n_tag;
      target_q[up_idx] <= n_tgt;
      jmp_q[up_idx]    <= n_jmp;
      ctr_q[up_idx]    <= n_ctr;
    end
  end

  // Flush sweep FSM
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    flush_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_req) begin
          state_d     = StFlush;
          ptr_d       = '0;
          flush_start = 1'b1;
        end
      end
      StFlush: begin
        ptr_d = ptr_q + INDEXBITS'(1);
        if (ptr_q == LastIdx) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Mispredict detection runs regardless of flush state
  logic [DBITS-1:0]   actual;
  logic               mispred_d;
  logic [CNTBITS-1:0] cnt_d;

  assign actual    = (up_ctl && upd_taken) ? upd_target : upd_pc + Inc;
  assign mispred_d = upd_valid && (actual != upd_predpc);

  always_comb begin
    cnt_d = mispred_cnt;
    if (flush_start) begin
      cnt_d = '0;
    end else if (mispred_d && (mispred_cnt != '1)) begin
      cnt_d = mispred_cnt + CNTBITS'(1);
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      mispred_EX  <= 1'b0;
      pcgood_EX   <= '0;
      mispred_cnt <= '0;
    end else begin
      mispred_EX  <= mispred_d;
      pcgood_EX   <= actual;
      mispred_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Directed bench for btb_branch_predictor: vector table plus flush, saturation
// and mid-flush reset sequences.
module tb_btb_branch_predictor;

  logic        clk;
  logic        RESET_N;
  logic [31:0] pc_FE;
  logic [31:0] pcpred_FE;
  logic        predtaken_FE;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_predpc;
  logic        upd_is_br;
  logic        upd_is_jmp;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush_req;
  logic        busy;
  logic        mispred_EX;
  logic [31:0] pcgood_EX;
  logic [15:0] mispred_cnt;

  int checks = 0;
  int errors = 0;

  btb_branch_predictor dut (
    .clk          (clk),
    .RESET_N      (RESET_N),
    .pc_FE        (pc_FE),
    .pcpred_FE    (pcpred_FE),
    .predtaken_FE (predtaken_FE),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_predpc   (upd_predpc),
    .upd_is_br    (upd_is_br),
    .upd_is_jmp   (upd_is_jmp),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .flush_req    (flush_req),
    .busy         (busy),
    .mispred_EX   (mispred_EX),
    .pcgood_EX    (pcgood_EX),
    .mispred_cnt  (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_fe;
    logic        uv, br, jmp, tk;
    logic [31:0] upc, upred, utgt;
    logic [31:0] e_pred;
    logic        e_pt;
    logic        e_mis;
    logic [31:0] e_good;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_upd(input logic v, input logic br, input logic jmp, input logic tk,
                           input logic [31:0] pc, input logic [31:0] pred,
                           input logic [31:0] tgt);
    upd_valid  = v;
    upd_is_br  = br;
    upd_is_jmp = jmp;
    upd_taken  = tk;
    upd_pc     = pc;
    upd_predpc = pred;
    upd_target = tgt;
  endtask

  task automatic lookup(input string name, input logic [31:0] pc,
                        input logic [31:0] e_pred, input logic e_pt);
    pc_FE = pc;
    #1;
    chk({name, " pcpred"}, pcpred_FE, e_pred);
    chk({name, " predtaken"}, {31'd0, predtaken_FE}, {31'd0, e_pt});
  endtask

  int nbusy;

  initial begin
    vecs[0]  = '{32'h120, 1, 1, 0, 1, 32'h120, 32'h124, 32'h200, 32'h124, 0, 1, 32'h200, 16'd1};
    vecs[1]  = '{32'h120, 1, 1, 0, 0, 32'h120, 32'h200, 32'h0, 32'h200, 1, 1, 32'h124, 16'd2};
    vecs[2]  = '{32'h120, 1, 1, 0, 0, 32'h120, 32'h124, 32'h0, 32'h124, 0, 0, 32'h124, 16'd2};
    vecs[3]  = '{32'h120, 1, 1, 0, 0, 32'h120, 32'h124, 32'h0, 32'h124, 0, 0, 32'h124, 16'd2};
    vecs[4]  = '{32'h120, 1, 1, 0, 1, 32'h120, 32'h124, 32'h200, 32'h124, 0, 1, 32'h200, 16'd3};
    vecs[5]  = '{32'h120, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h124, 0, 0, 32'h4, 16'd3};
    vecs[6]  = '{32'h140, 1, 0, 1, 1, 32'h140, 32'h144, 32'h300, 32'h144, 0, 1, 32'h300, 16'd4};
    vecs[7]  = '{32'h140, 1, 0, 0, 1, 32'h10140, 32'h10144, 32'h999, 32'h300, 1, 0, 32'h10144,
                 16'd4};
    vecs[8]  = '{32'h140, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h144, 0, 0, 32'h4, 16'd4};
    vecs[9]  = '{32'hFFFFFFFC, 1, 0, 1, 1, 32'hFFFFFFFC, 32'h0, 32'h80, 32'h0, 0, 1, 32'h80,
                 16'd5};
    vecs[10] = '{32'hFFFFFFFC, 1, 0, 1, 1, 32'hFFFFFFFC, 32'h80, 32'h80, 32'h80, 1, 0, 32'h80,
                 16'd5};
    vecs[11] = '{32'h3C, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h40, 0, 0, 32'h4, 16'd5};
    vecs[12] = '{32'hFFFFFFFC, 1, 1, 0, 0, 32'h3C, 32'h40, 32'h0, 32'h80, 1, 0, 32'h40, 16'd5};
    vecs[13] = '{32'hFFFFFFFC, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h80, 1, 0, 32'h4, 16'd5};

    RESET_N   = 1'b0;
    flush_req = 1'b0;
    pc_FE     = 32'h100;
    drive_upd(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    #2;
    lookup("reset", 32'h100, 32'h104, 1'b0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset mispred_EX", {31'd0, mispred_EX}, 32'd0);
    chk("reset pcgood_EX", pcgood_EX, 32'd0);
    chk("reset mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
    @(negedge clk);
    RESET_N = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      drive_upd(vecs[i].uv, vecs[i].br, vecs[i].jmp, vecs[i].tk,
                vecs[i].upc, vecs[i].upred, vecs[i].utgt);
      lookup($sformatf("vec%0d", i), vecs[i].pc_fe, vecs[i].e_pred, vecs[i].e_pt);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d mispred_EX", i), {31'd0, mispred_EX}, {31'd0, vecs[i].e_mis});
      chk($sformatf("vec%0d pcgood_EX", i), pcgood_EX, vecs[i].e_good);
      chk($sformatf("vec%0d mispred_cnt", i), {16'd0, mispred_cnt}, {16'd0, vecs[i].e_cnt});
    end

    // Fill every entry with a JAL, then sweep it away
    for (int i = 0; i < 16; i++) begin
      drive_upd(1, 0, 1, 1, 32'h1000 + i * 4, 32'h1004 + i * 4, 32'h2000 + i * 4);
      @(posedge clk);
      #1;
    end
    drive_upd(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++)
      lookup($sformatf("fill%0d", i), 32'h1000 + i * 4, 32'h2000 + i * 4, 1'b1);

    flush_req = 1'b1;
    drive_upd(1, 1, 0, 1, 32'h5000, 32'h5004, 32'h5800);
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    drive_upd(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    nbusy = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      nbusy++;
      if (c == 3) begin
        drive_upd(1, 0, 1, 1, 32'h6004, 32'h7000, 32'h7000);
        flush_req = 1'b1;
      end else begin
        drive_upd(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        flush_req = 1'b0;
      end
      if (c == 8) lookup("during flush", 32'h1020, 32'h1024, 1'b0);
      @(posedge clk);
      #1;
    end
    drive_upd(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    flush_req = 1'b0;
    chk("flush busy cycles", nbusy, 32'd16);
    chk("post flush busy", {31'd0, busy}, 32'd0);
    chk("post flush mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
    for (int i = 0; i < 16; i++)
      lookup($sformatf("flushed%0d", i), 32'h1000 + i * 4, 32'h1004 + i * 4, 1'b0);
    lookup("dropped upd at flush_req", 32'h5000, 32'h5004, 1'b0);
    lookup("dropped upd mid flush", 32'h6004, 32'h6008, 1'b0);

    // Counter saturation: non-branch at PC 0 with predpc 0 mispredicts every cycle
    drive_upd(1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    repeat (65539) @(posedge clk);
    #1;
    chk("saturated mispred_cnt", {16'd0, mispred_cnt}, 32'h0000FFFF);

    // Reset in the middle of a flush
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid flush busy", {31'd0, busy}, 32'd1);
    chk("mid flush mispred_cnt", {16'd0, mispred_cnt}, 32'd5);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async reset busy", {31'd0, busy}, 32'd0);
    chk("async reset mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
    chk("async reset mispred_EX", {31'd0, mispred_EX}, 32'd0);
    chk("async reset pcgood_EX", pcgood_EX, 32'd0);
    drive_upd(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    RESET_N = 1'b1;
    @(posedge clk);
    #1;
    chk("after reset busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_branch_predictor.md
Name: btb_branch_predictor

Overview:
- Fetch-stage next-PC predictor for the 5-stage pipeline: a direct-mapped branch target buffer with per-entry saturating counters.
- Gives FE a combinational predicted PC and takes resolved outcomes from EX.
- Registers mispred_EX/pcgood_EX for the PC redirect.
- Supports a software/debug table flush driven by a sweep FSM, and keeps a mispredict statistics counter.

Parameters:
- DBITS, 32, PC/target width.
- INSTSIZE, 4, fall-through PC increment.
- INDEXBITS, 4, log2 of entry count (ENTRIES = 1<<INDEXBITS).
- TAGBITS, 10, PC tag bits stored per entry.
- CTRBITS, 2, saturating counter width (>=2).
- CNTBITS, 16, mispredict counter width.

Ports:
- clk  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous active-low reset.
- pc_FE  in  DBITS  PC being fetched.
- pcpred_FE  out  DBITS  predicted next PC (combinational).
- predtaken_FE  out  1  prediction is taken (combinational).
- upd_valid  in  1  EX has a resolved instruction this cycle.
- upd_pc  in  DBITS  PC of the resolved instruction.
- upd_predpc  in  DBITS  next-PC predicted at fetch, carried down the pipe.
- upd_is_br  in  1  instruction is a conditional branch.
- upd_is_jmp  in  1  instruction is JAL.
- upd_taken  in  1  branch/jump actually taken (ignored unless is_br/is_jmp).
- upd_target  in  DBITS  actual target when taken.
- flush_req  in  1  start a table flush.
- busy  out  1  flush in progress.
- mispred_EX  out  1  registered redirect request.
- pcgood_EX  out  DBITS  registered correct next PC.
- mispred_cnt  out  CNTBITS  saturating mispredict count.

Behaviour:
- Indexing:
  - idx = pc[INDEXBITS+1:2].
  - tag = pc[TAGBITS+INDEXBITS+1:INDEXBITS+2].
  - Entry fields: valid, tag, target, jmp flag, ctr.
- Lookup (combinational, on pc_FE):
  - hit = valid && tag match && !busy.
  - predtaken_FE = hit && (jmp || ctr MSB).
  - pcpred_FE = predtaken_FE ? target : pc_FE + INSTSIZE.
  - Wrap-around is mod 2^DBITS.
- Table update (posedge clk): when upd_valid && !busy && !flush_req:
  - Branch/jump with a hit on upd_pc:
    - is_br: ctr increments if taken, decrements if not, saturating at 0 and 2^CTRBITS-1.
    - is_jmp: ctr set to max and jmp=1.
    - Target is overwritten only when taken.
  - Branch/jump with a miss and taken: allocate (replacing any occupant).
    - valid=1, tag, target.
    - jmp=upd_is_jmp.
    - ctr = 2^(CTRBITS-1) (weakly taken).
  - Branch/jump with a miss and not taken: no change.
  - Neither is_br nor is_jmp, with a hit: invalidate that entry (aliasing cleanup).
- Same-cycle lookup and update of the same index: lookup sees the pre-update contents.
- Mispredict (computed every cycle, independent of busy/flush):
  - actual = ((upd_is_br||upd_is_jmp) && upd_taken) ? upd_target : upd_pc + INSTSIZE.
  - mispred_EX <= upd_valid && (actual != upd_predpc).
  - pcgood_EX <= actual.
  - Latency is one cycle.
  - mispred_cnt increments on each registered mispredict and holds at all-ones.
- Flush FSM:
  - States: IDLE, FLUSH.
  - IDLE + flush_req → FLUSH with ptr=0.
  - In FLUSH: entry[ptr].valid cleared each cycle and ptr increments; after ptr = ENTRIES-1 → IDLE.
  - busy=1 exactly ENTRIES cycles, starting the cycle after flush_req.
  - flush_req while busy is ignored.
  - Updates in the flush_req cycle and during FLUSH are dropped.
  - mispred_cnt is cleared on flush entry.
- Reset (asynchronous, RESET_N=0):
  - All valid=0 and all ctr = 2^(CTRBITS-1)-1.
  - FSM=IDLE, busy=0, mispred_EX=0, pcgood_EX=0, mispred_cnt=0.
  - Reset asserted mid-flush aborts the flush immediately.
- Outputs after reset: predtaken_FE=0, pcpred_FE=pc_FE+INSTSIZE.

Test Plan:
- Reset, pc_FE=0x100 → pcpred_FE=0x104, predtaken_FE=0, busy=0, mispred_cnt=0.
- Update: upd_pc=0x120, br, taken, target=0x200, upd_predpc=0x124 → next cycle mispred_EX=1, pcgood_EX=0x200, mispred_cnt=1. Then lookup 0x120 → pcpred_FE=0x200.
- Same branch resolved not-taken twice → ctr 10→01→00. Lookup 0x120 → 0x124. A third not-taken holds at 00.
- JAL at 0x140, target 0x300, then aliasing PC 0x140+(1<<(INDEXBITS+2+TAGBITS)), non-branch, upd_valid → entry invalidated; lookup 0x140 → 0x144.
- flush_req with 16 valid entries → busy=1 for exactly 16 cycles. An update mid-flush is dropped. After the flush, all lookups miss and mispred_cnt=0.
- Drive 2^CNTBITS+3 mispredicts → mispred_cnt saturates at 0xFFFF. Assert RESET_N low mid-flush → busy=0 and mispred_cnt=0 immediately.
